// File: rtl/nibble_adder_pkg.sv
// Shared constants and state encoding for the
// nibble-serial adder and its 4-bit datapath.
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } nsa_state_t;

endpackage

// File: rtl/top_carry_select_adder.sv
// 4-bit carry-select adder: ripple low pair,
// precomputed upper pair for both carries.
module top_carry_select_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [2:0] lo;
  logic [2:0] hi0;
  logic [2:0] hi1;

  // Low pair ripples; the low carry selects the upper result.
  always_comb begin
    lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
    sum[1:0] = lo[1:0];
    {cout, sum[3:2]} = lo[2] ? hi1 : hi0;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one nibble per cycle through
// a 4-bit carry-select adder, LSB nibble first.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  nsa_state_t state;
  logic [CW-1:0] cnt;
  logic carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_sh_nx;
  logic [NIBBLE_W-1:0] nib;
  logic nib_co;

  top_carry_select_adder u_csa (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry),
    .sum  (nib),
    .cout (nib_co)
  );

  // Handshake and status flags decode straight from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // New nibble enters at the top as the partial sum shifts down.
  always_comb begin
    sum_sh_nx = (sum_sh >> NIBBLE_W)
              | (WIDTH'(nib) << (WIDTH - NIBBLE_W));
  end

  // Control FSM plus operand/sum shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_sh <= sum_sh_nx;
          a_sh   <= a_sh >> NIBBLE_W;
          b_sh   <= b_sh >> NIBBLE_W;
          carry  <= nib_co;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= sum_sh_nx;
            cout  <= nib_co;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench: directed vectors and hold/abort sequences at
// WIDTH=16, scoreboarded random ops at 4/16/32.
module tb_nibble_serial_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] s;
    logic        co;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] iv;
  logic [2:0] orr;
  logic [2:0] tcin;
  logic [2:0] ir;
  logic [2:0] ov;
  logic [2:0] bz;
  logic [2:0] co;
  logic [31:0] ta [3];
  logic [31:0] tbv [3];
  logic [3:0] s4;
  logic [15:0] s16;
  logic [31:0] s32;

  int n_pass = 0;
  int n_total = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .a(ta[0][3:0]), .b(tbv[0][3:0]), .cin(tcin[0]),
    .out_valid(ov[0]), .out_ready(orr[0]),
    .sum(s4), .cout(co[0]), .busy(bz[0])
  );

  nibble_serial_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .a(ta[1][15:0]), .b(tbv[1][15:0]), .cin(tcin[1]),
    .out_valid(ov[1]), .out_ready(orr[1]),
    .sum(s16), .cout(co[1]), .busy(bz[1])
  );

  nibble_serial_adder #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .a(ta[2]), .b(tbv[2]), .cin(tcin[2]),
    .out_valid(ov[2]), .out_ready(orr[2]),
    .sum(s32), .cout(co[2]), .busy(bz[2])
  );

  function automatic logic [31:0] rd_sum(input int k);
    case (k)
      0:       return {28'h0, s4};
      1:       return {16'h0, s16};
      default: return s32;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b,
                      input logic c, input logic [15:0] es,
                      input logic ec, input string nm);
    int lat;
    @(negedge clk);
    ta[1] = {16'h0, a};
    tbv[1] = {16'h0, b};
    tcin[1] = c;
    iv[1] = 1'b1;
    chk({nm, "_rdy"}, 64'(ir[1]), 64'd1);
    @(posedge clk);
    #1;
    iv[1] = 1'b0;
    ta[1] = 32'hFFFF;
    tbv[1] = 32'hFFFF;
    tcin[1] = ~c;
    lat = 0;
    while (!ov[1] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'd4);
    chk({nm, "_sum"}, 64'(s16), 64'(es));
    chk({nm, "_cout"}, 64'(co[1]), 64'(ec));
  endtask

  task automatic release16(input string nm);
    @(negedge clk);
    orr[1] = 1'b1;
    @(posedge clk);
    #1;
    orr[1] = 1'b0;
    chk({nm, "_idle_rdy"}, 64'(ir[1]), 64'd1);
    chk({nm, "_idle_ov"}, 64'(ov[1]), 64'd0);
  endtask

  task automatic run_rand(input int k, input int w, input int n);
    logic [63:0] m;
    logic [63:0] full;
    exp_t e;
    int sent;
    int got;
    m = (w == 32) ? 64'hFFFF_FFFF : ((64'd1 << w) - 64'd1);
    sent = 0;
    got = 0;
    q.delete();
    for (int cyc = 0; cyc < n * 20 && got < n; cyc++) begin
      @(negedge clk);
      iv[k] = (sent < n);
      ta[k] = $urandom() & m[31:0];
      tbv[k] = $urandom() & m[31:0];
      tcin[k] = 1'($urandom());
      orr[k] = 1'($urandom());
      if (iv[k] && ir[k]) begin
        full = 64'(ta[k]) + 64'(tbv[k]) + 64'(tcin[k]);
        e.s = 32'(full & m);
        e.c = full[w];
        q.push_back(e);
        sent++;
      end
      if (ov[k] && orr[k]) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL sb_underflow w%0d: got output expected none", w);
        end else begin
          e = q.pop_front();
          chk($sformatf("rand_w%0d_sum", w), 64'(rd_sum(k)), 64'(e.s));
          chk($sformatf("rand_w%0d_cout", w), 64'(co[k]), 64'(e.c));
        end
        got++;
      end
    end
    @(negedge clk);
    iv[k] = 1'b0;
    orr[k] = 1'b0;
    chk($sformatf("rand_w%0d_count", w), 64'(got), 64'(n));
  endtask

  initial begin
    vec_t vt [6];
    vt[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vt[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vt[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vt[4] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0};
    vt[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};

    rst_n = 1'b0;
    iv = '0;
    orr = '0;
    tcin = '0;
    for (int k = 0; k < 3; k++) begin
      ta[k] = '0;
      tbv[k] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_sum", 64'(s16), 64'd0);
    chk("rst_cout", 64'(co[1]), 64'd0);
    chk("rst_ov", 64'(ov[1]), 64'd0);
    chk("rst_busy", 64'(bz[1]), 64'd0);
    chk("rst_rdy", 64'(ir[1]), 64'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      op16(vt[i].a, vt[i].b, vt[i].c, vt[i].s, vt[i].co,
           $sformatf("vec%0d", i));
      release16($sformatf("vec%0d", i));
    end

    op16(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, "hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv[1] = (i == 2);
      ta[1] = 32'h0F0F;
      tbv[1] = 32'h0101;
      @(posedge clk);
      #1;
      iv[1] = 1'b0;
      chk("hold_sum", 64'(s16), 64'h2345);
      chk("hold_cout", 64'(co[1]), 64'd0);
      chk("hold_rdy", 64'(ir[1]), 64'd0);
      chk("hold_ov", 64'(ov[1]), 64'd1);
    end
    release16("hold");
    repeat (8) @(posedge clk);
    #1;
    chk("hold_no_queue_ov", 64'(ov[1]), 64'd0);
    chk("hold_sum_kept", 64'(s16), 64'h2345);

    @(negedge clk);
    ta[1] = 32'hABCD;
    tbv[1] = 32'h1111;
    tcin[1] = 1'b1;
    iv[1] = 1'b1;
    @(posedge clk);
    #1;
    iv[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_busy", 64'(bz[1]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_sum", 64'(s16), 64'd0);
    chk("abort_cout", 64'(co[1]), 64'd0);
    chk("abort_ov", 64'(ov[1]), 64'd0);
    chk("abort_busy0", 64'(bz[1]), 64'd0);
    chk("abort_rdy", 64'(ir[1]), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_ov", 64'(ov[1]), 64'd0);
    op16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "post_abort");
    release16("post_abort");

    run_rand(1, 16, 1000);
    run_rand(0, 4, 1000);
    run_rand(2, 32, 1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
